// File: rtl/rs_issue_sched_pkg.sv
// rtl/rs_issue_sched_pkg.sv - RS issue scheduler sizes and FSM state encoding
`ifndef RS_LEN
`define RS_LEN 8
`endif

package rs_issue_sched_pkg;
  localparam int RS_LEN   = `RS_LEN;
  localparam int RS_IDX_W = (RS_LEN > 1) ? $clog2(RS_LEN) : 1;

  typedef enum logic {
    RS_SCHED_IDLE  = 1'b0,
    RS_SCHED_VALID = 1'b1
  } rs_sched_state_e;
endpackage

// File: rtl/rs_issue_sched_if.sv
// rtl/rs_issue_sched_if.sv - FU issue port handshake between scheduler and FU/issue mux
interface rs_issue_sched_if;
  import rs_issue_sched_pkg::*;

  logic                issue_valid;
  logic [RS_IDX_W-1:0] issue_idx;
  logic [RS_LEN-1:0]   issue_onehot;
  logic [RS_LEN-1:0]   rs_entry_clear_out;
  logic                fu_ready;

  modport master (
    output issue_valid, issue_idx, issue_onehot, rs_entry_clear_out,
    input  fu_ready
  );

  modport slave (
    input  issue_valid, issue_idx, issue_onehot, rs_entry_clear_out,
    output fu_ready
  );
endinterface

// File: rtl/rs_issue_sched_rr_picker.sv
// rtl/rs_issue_sched_rr_picker.sv - rotate-priority encoder (rs_rr_picker): first req at or after ptr
module rs_rr_picker #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);
  logic [W-1:0] cand;

  // Scan from ptr upward, wrapping modulo N; the first request found wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = W'((int'(ptr) + k) % N);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_onehot = gnt_valid ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - RS issue scheduler; define RS_SCHED_AGE_EN for oldest-first selection
module rs_issue_sched
  import rs_issue_sched_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [RS_LEN-1:0] rs_entry_busy,
  input  logic [RS_LEN-1:0] rs_entry_ready,
  input  logic [RS_LEN-1:0] rs_entry_alloc,
  input  logic              squash,
  rs_issue_sched_if.master  iss
);
  rs_sched_state_e     state_q, state_d;
  logic [RS_IDX_W-1:0] idx_q, idx_d, win_idx;
  logic [RS_LEN-1:0]   held_onehot, elig;
  logic                win_valid, held_lost, fire;

  assign iss.issue_valid  = (state_q == RS_SCHED_VALID);
  assign held_onehot      = iss.issue_valid ? (RS_LEN'(1) << idx_q) : '0;
  assign iss.issue_idx    = idx_q;
  assign iss.issue_onehot = held_onehot;

  // The RS may free the held entry behind our back; that issue is abandoned silently.
  assign held_lost = iss.issue_valid & ~rs_entry_busy[idx_q];
  assign fire      = iss.issue_valid & iss.fu_ready & ~squash & ~held_lost;
  assign iss.rs_entry_clear_out = fire ? held_onehot : '0;

`ifdef RS_SCHED_AGE_EN
  // age_q[j][i] = 1 means entry j is older than entry i.
  logic [RS_LEN-1:0] age_q [RS_LEN];
  logic              blocked;

  // A freshly allocated entry is youngest and cannot be picked in its allocation cycle.
  assign elig = rs_entry_busy & rs_entry_ready & ~held_onehot & ~rs_entry_alloc;

  // Age matrix: new entry becomes younger than every other entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < RS_LEN; j++) age_q[j] <= '0;
    end else begin
      for (int i = 0; i < RS_LEN; i++) begin
        if (rs_entry_alloc[i]) begin
          for (int j = 0; j < RS_LEN; j++) begin
            age_q[j][i] <= (j != i);
            age_q[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // Oldest-first pick: an eligible entry with no older eligible entry; lowest index breaks ties.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    blocked   = 1'b0;
    for (int i = 0; i < RS_LEN; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RS_LEN; j++) blocked = blocked | (elig[j] & age_q[j][i]);
      if (!win_valid && elig[i] && !blocked) begin
        win_valid = 1'b1;
        win_idx   = RS_IDX_W'(i);
      end
    end
  end
`else
  logic [RS_IDX_W-1:0] rr_ptr_q;
  logic [RS_LEN-1:0]   unused_gnt_onehot;

  assign elig = rs_entry_busy & rs_entry_ready & ~held_onehot;

  // Round-robin pointer moves just past each issued entry; squash leaves it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else if (fire) begin
      rr_ptr_q <= (idx_q == RS_IDX_W'(RS_LEN - 1)) ? '0 : idx_q + RS_IDX_W'(1);
    end
  end

  rs_rr_picker #(.N(RS_LEN), .W(RS_IDX_W)) u_rr_picker (
    .req        (elig),
    .ptr        (rr_ptr_q),
    .gnt_onehot (unused_gnt_onehot),
    .gnt_idx    (win_idx),
    .gnt_valid  (win_valid)
  );
`endif

  // Issue state and held index registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RS_SCHED_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: load a winner when idle or after a fire; hold steady while stalled.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      RS_SCHED_IDLE: begin
        if (!squash && win_valid) begin
          state_d = RS_SCHED_VALID;
          idx_d   = win_idx;
        end
      end
      RS_SCHED_VALID: begin
        if (squash || held_lost) begin
          state_d = RS_SCHED_IDLE;
        end else if (fire) begin
          if (win_valid) idx_d = win_idx;
          else           state_d = RS_SCHED_IDLE;
        end
      end
      default: state_d = RS_SCHED_IDLE;
    endcase
  end

  // At most one entry may be allocated per cycle.
  always @(posedge clock) begin
    if (reset) alloc_onehot0: assert ($onehot0(rs_entry_alloc));
  end
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - directed bench with issue-order scoreboard for rs_issue_sched
module tb_rs_issue_sched;
  import rs_issue_sched_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [RS_LEN-1:0] busy  = '0;
  logic [RS_LEN-1:0] ready = '0;
  logic [RS_LEN-1:0] alloc = '0;
  logic              squash = 1'b0;
  int                checks = 0;
  int                errors = 0;
  int                exp_q[$];

  rs_issue_sched_if ifc();

  rs_issue_sched dut (
    .clock          (clock),
    .reset          (reset),
    .rs_entry_busy  (busy),
    .rs_entry_ready (ready),
    .rs_entry_alloc (alloc),
    .squash         (squash),
    .iss            (ifc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    checks++;
    assert (obs === req_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req_v);
    end
  endtask

  // Advance one clock; the RS frees whatever entry was cleared on that edge.
  task automatic cyc();
    logic [RS_LEN-1:0] c;
    c = ifc.rs_entry_clear_out;
    @(posedge clock);
    #1;
    busy  = busy & ~c;
    ready = ready & ~c;
  endtask

  // Compare a handshake against the next expected issue.
  task automatic sb(input string tag);
    int e;
    chk({tag, "_valid"}, ifc.issue_valid, 1);
    if (ifc.issue_valid && ifc.fu_ready && !squash) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_extra"}, ifc.issue_idx, 32'hffff);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_idx"}, ifc.issue_idx, e);
        chk({tag, "_clr"}, ifc.rs_entry_clear_out, 1 << e);
      end
    end
  endtask

  initial begin
    ifc.fu_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid",  ifc.issue_valid, 0);
    chk("rst_idx",    ifc.issue_idx, 0);
    chk("rst_onehot", ifc.issue_onehot, 0);
    chk("rst_clear",  ifc.rs_entry_clear_out, 0);
    reset = 1'b1;
    cyc();

`ifdef RS_SCHED_AGE_EN
    alloc = 8'h20; busy = 8'h20; cyc();
    alloc = 8'h04; busy = busy | 8'h04; cyc();
    alloc = 8'h40; busy = busy | 8'h40; cyc();
    alloc = 8'h00; ready = 8'h64; ifc.fu_ready = 1'b1;
    exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(6);
    #1 chk("age_idle", ifc.issue_valid, 0); cyc();
    #1 sb("age_a"); cyc();
    #1 sb("age_b"); cyc();
    #1 sb("age_c"); cyc();
    #1 chk("age_end", ifc.issue_valid, 0);
    ifc.fu_ready = 1'b0;
`else
    busy = 8'h05; ready = 8'h05; ifc.fu_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(2);
    #1 chk("t2_idle", ifc.issue_valid, 0); cyc();
    #1 sb("t2_a"); cyc();
    #1 sb("t2_b"); cyc();
    #1 chk("t2_end", ifc.issue_valid, 0);

    busy = 8'h0a; ready = 8'h0a; ifc.fu_ready = 1'b0;
    #1 cyc();
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t3_hold_valid", ifc.issue_valid, 1);
      chk("t3_hold_idx",   ifc.issue_idx, 3);
      chk("t3_hold_clr",   ifc.rs_entry_clear_out, 0);
      cyc();
    end
    ifc.fu_ready = 1'b1;
    exp_q.push_back(3); exp_q.push_back(1);
    #1 sb("t3_a"); cyc();
    #1 sb("t3_b"); cyc();
    #1 chk("t3_end", ifc.issue_valid, 0);

    busy = 8'h40; ready = 8'h40; exp_q.push_back(6);
    #1 cyc();
    #1 sb("t4_pre"); cyc();
    busy = 8'h81; ready = 8'h81; exp_q.push_back(7); exp_q.push_back(0);
    #1 chk("t4_idle", ifc.issue_valid, 0); cyc();
    #1 sb("t4_a"); cyc();
    #1 sb("t4_b"); cyc();
    #1 chk("t4_end", ifc.issue_valid, 0);

    busy = 8'h10; ready = 8'h10; ifc.fu_ready = 1'b0;
    #1 cyc();
    #1 chk("t5_idx", ifc.issue_idx, 4);
    squash = 1'b1; ifc.fu_ready = 1'b1;
    #1 chk("t5_sq_clr", ifc.rs_entry_clear_out, 0);
    cyc();
    squash = 1'b0; ifc.fu_ready = 1'b0;
    #1 chk("t5_dropped", ifc.issue_valid, 0); cyc();
    #1 chk("t5_reissue_idx", ifc.issue_idx, 4);
    ifc.fu_ready = 1'b1; exp_q.push_back(4);
    #1 sb("t5_a"); cyc();
    #1 chk("t5_end", ifc.issue_valid, 0);
`endif

    busy = 8'h20; ready = 8'h20; ifc.fu_ready = 1'b0;
    #1 cyc();
    #1 chk("lost_valid", ifc.issue_valid, 1);
    chk("lost_idx", ifc.issue_idx, 5);
    busy = 8'h00; ready = 8'h00; ifc.fu_ready = 1'b1;
    #1 chk("lost_clr", ifc.rs_entry_clear_out, 0);
    cyc();
    #1 chk("lost_idle", ifc.issue_valid, 0);

    busy = 8'h08; ready = 8'h08; ifc.fu_ready = 1'b0;
    #1 cyc();
    ifc.fu_ready = 1'b1;
    #1 chk("t1_pre_clr", ifc.rs_entry_clear_out, 8'h08);
    #2 reset = 1'b0;
    #1;
    chk("t1_valid",  ifc.issue_valid, 0);
    chk("t1_clr",    ifc.rs_entry_clear_out, 0);
    chk("t1_onehot", ifc.issue_onehot, 0);
    busy = '0; ready = '0; ifc.fu_ready = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    cyc();

    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
